// File: rtl/speed_tickgen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : speed_tickgen_pkg
//  Description : Shared constants and types for the game-tick generator.
//                Holds the default counter width, period bounds and the
//                acceleration interval used as parameter defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package speed_tickgen_pkg;

    localparam int c_cnt_w          = 5;
    localparam int c_default_period = 3;   // frames per tick = period + 1
    localparam int c_min_period     = 1;   // fastest allowed period
    localparam int c_max_period     = 31;  // slowest allowed period
    localparam int c_accel_every    = 4;   // issued ticks per auto speed-up

    typedef logic [c_cnt_w-1:0] period_t;

endpackage : speed_tickgen_pkg
`default_nettype wire

// File: rtl/speed_tickgen_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : rise_detect
//  Description : 1-bit rising-edge detector. The previous level is
//                registered; the output is combinational (high in the
//                cycle where the input is 1 and was 0 on the prior edge).
//  Ports       : clk     - system clock
//                rst     - synchronous reset, active-high (prev level -> 0)
//                i_d     - input level
//                o_rise  - i_d & ~previous i_d
//  Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_d;
        end
    end

    assign o_rise = i_d & ~r_prev;

endmodule : rise_detect
`default_nettype wire

// File: rtl/speed_tickgen.sv
`default_nettype none
// ============================================================================
//  Module      : speed_tickgen
//  Description : Game-tick generator. Counts vsync rising edges and raises
//                a level tick every (period+1) frames. Supports saturating
//                user speed adjust (in restart/menu), automatic
//                acceleration, pause, and overrun reporting.
//  Ports       : clk         - system clock
//                rst         - synchronous reset, active-high
//                i_up        - increase period (slower), restart only
//                i_down      - decrease period (faster), restart only
//                i_restart   - restart / menu level
//                i_pause     - freeze frame counting
//                i_accel_en  - enable automatic acceleration
//                i_vsync     - vsync level
//                i_tick_done - core consumed the pending tick
//                o_tick      - tick pending (level)
//                o_period    - live period in use
//                o_overrun   - 1-cycle pulse, tick due while one pending
//  Revision    : 1.0 - initial release
// ============================================================================
module speed_tickgen
    import speed_tickgen_pkg::*;
#(
    parameter int CNT_W          = c_cnt_w,
    parameter int DEFAULT_PERIOD = c_default_period,
    parameter int MIN_PERIOD     = c_min_period,
    parameter int MAX_PERIOD     = c_max_period,
    parameter int ACCEL_EVERY    = c_accel_every
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_up,
    input  logic             i_down,
    input  logic             i_restart,
    input  logic             i_pause,
    input  logic             i_accel_en,
    input  logic             i_vsync,
    input  logic             i_tick_done,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_period,
    output logic             o_overrun
);

    localparam int               c_acc_w    = $clog2(ACCEL_EVERY + 1);
    localparam logic [c_acc_w-1:0] c_acc_last = c_acc_w'(ACCEL_EVERY - 1);
    localparam logic [CNT_W:0]   c_min_ext  = (CNT_W + 1)'(MIN_PERIOD);
    localparam logic [CNT_W:0]   c_max_ext  = (CNT_W + 1)'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] c_default  = CNT_W'(DEFAULT_PERIOD);

    // One saturating step of the period. Arithmetic is one bit wider than
    // the period so neither direction can wrap before the clamp.
    function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] v,
                                                  input logic             inc);
        logic [CNT_W:0] ext;
        ext = {1'b0, v};
        if (inc) begin
            ext = ext + (CNT_W + 1)'(1);
            if (ext > c_max_ext) ext = c_max_ext;
        end else begin
            if (ext <= c_min_ext) ext = c_min_ext;
            else                  ext = ext - (CNT_W + 1)'(1);
        end
        return ext[CNT_W-1:0];
    endfunction

    logic [CNT_W-1:0]   r_base_period;
    logic [CNT_W-1:0]   r_cur_period;
    logic [CNT_W-1:0]   r_counter;
    logic [c_acc_w-1:0] r_accel_cnt;
    logic               r_tick;
    logic               r_overrun;

    logic w_frame;
    logic w_btn_rise;
    logic w_count_frame;
    logic w_due;
    logic w_issue;
    logic w_overrun;
    logic w_accel_wrap;

    rise_detect u_vsync_rise (
        .clk    (clk),
        .rst    (rst),
        .i_d    (i_vsync),
        .o_rise (w_frame)
    );

    rise_detect u_btn_rise (
        .clk    (clk),
        .rst    (rst),
        .i_d    (i_up | i_down),
        .o_rise (w_btn_rise)
    );

    // >= rather than == because acceleration can pull cur_period below
    // a counter value already reached.
    assign w_count_frame = ~i_restart & ~i_pause & w_frame;
    assign w_due         = w_count_frame & (r_counter >= r_cur_period);
    // A done in the same cycle frees the slot, so the new tick is issued.
    assign w_issue       = w_due & (~r_tick | i_tick_done);
    assign w_overrun     = w_due & r_tick & ~i_tick_done;
    assign w_accel_wrap  = r_accel_cnt == c_acc_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base_period <= c_default;
            r_cur_period  <= c_default;
            r_counter     <= '0;
            r_accel_cnt   <= '0;
            r_tick        <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (i_restart && w_btn_rise) begin
                if (i_up && !i_down) begin
                    r_base_period <= sat_step(r_base_period, 1'b1);
                end else if (i_down && !i_up) begin
                    r_base_period <= sat_step(r_base_period, 1'b0);
                end
            end

            if (i_restart) begin
                // Non-blocking: picks up base_period before any same-cycle
                // adjust, giving o_period a one-cycle lag in the menu.
                r_cur_period <= r_base_period;
                r_counter    <= '0;
                r_accel_cnt  <= '0;
                r_tick       <= 1'b0;
                r_overrun    <= 1'b0;
            end else begin
                r_overrun <= w_overrun;

                if (w_count_frame) begin
                    r_counter <= w_due ? '0 : r_counter + CNT_W'(1);
                end

                if (w_issue) begin
                    r_tick <= 1'b1;
                end else if (!w_due && i_tick_done) begin
                    r_tick <= 1'b0;
                end

                if (w_issue && i_accel_en) begin
                    if (w_accel_wrap) begin
                        r_accel_cnt  <= '0;
                        r_cur_period <= sat_step(r_cur_period, 1'b0);
                    end else begin
                        r_accel_cnt  <= r_accel_cnt + c_acc_w'(1);
                    end
                end
            end
        end
    end

    assign o_tick    = r_tick;
    assign o_period  = r_cur_period;
    assign o_overrun = r_overrun;

endmodule : speed_tickgen
`default_nettype wire

// File: tb/tb_speed_tickgen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_speed_tickgen
//  Description : Self-checking bench for speed_tickgen. A frame/tick model
//                tracks expected outputs every cycle; directed scenarios
//                add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_speed_tickgen;

    localparam int P_CNT_W   = 5;
    localparam int P_DEFAULT = 3;
    localparam int P_MIN     = 1;
    localparam int P_MAX     = 31;
    localparam int P_ACCEL   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               i_up = 1'b0, i_down = 1'b0, i_restart = 1'b0;
    logic               i_pause = 1'b0, i_accel_en = 1'b0, i_vsync = 1'b0;
    logic               i_tick_done = 1'b0;
    logic               o_tick, o_overrun;
    logic [P_CNT_W-1:0] o_period;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    speed_tickgen #(
        .CNT_W          (P_CNT_W),
        .DEFAULT_PERIOD (P_DEFAULT),
        .MIN_PERIOD     (P_MIN),
        .MAX_PERIOD     (P_MAX),
        .ACCEL_EVERY    (P_ACCEL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_up        (i_up),
        .i_down      (i_down),
        .i_restart   (i_restart),
        .i_pause     (i_pause),
        .i_accel_en  (i_accel_en),
        .i_vsync     (i_vsync),
        .i_tick_done (i_tick_done),
        .o_tick      (o_tick),
        .o_period    (o_period),
        .o_overrun   (o_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (frames, ticks, speed) -------------
    int m_base, m_cur, m_frames, m_acc_ticks;
    int m_tick, m_ovr, m_prev_vs, m_prev_btn;
    bit m_valid = 1'b0;

    always @(posedge clk) begin : model
        int  old_base;
        bit  frame, press, due, issued;
        if (rst) begin
            m_base = P_DEFAULT; m_cur = P_DEFAULT; m_frames = 0; m_acc_ticks = 0;
            m_tick = 0; m_ovr = 0; m_prev_vs = 0; m_prev_btn = 0;
            m_valid = 1'b1;
        end else begin
            frame      = i_vsync && (m_prev_vs == 0);
            press      = (i_up || i_down) && (m_prev_btn == 0);
            m_prev_vs  = i_vsync;
            m_prev_btn = (i_up || i_down) ? 1 : 0;
            old_base   = m_base;
            if (i_restart && press) begin
                if (i_up && !i_down)      m_base = (m_base + 1 > P_MAX) ? P_MAX : m_base + 1;
                else if (i_down && !i_up) m_base = (m_base - 1 < P_MIN) ? P_MIN : m_base - 1;
            end
            if (i_restart) begin
                m_cur = old_base; m_frames = 0; m_acc_ticks = 0; m_tick = 0; m_ovr = 0;
            end else begin
                due = 0; issued = 0; m_ovr = 0;
                if (!i_pause && frame) begin
                    if (m_frames >= m_cur) begin m_frames = 0; due = 1; end
                    else m_frames++;
                end
                if (due) begin
                    if (m_tick == 0 || i_tick_done) begin m_tick = 1; issued = 1; end
                    else m_ovr = 1;
                end else if (i_tick_done) m_tick = 0;
                if (issued && i_accel_en) begin
                    m_acc_ticks++;
                    if (m_acc_ticks == P_ACCEL) begin
                        m_acc_ticks = 0;
                        m_cur = (m_cur - 1 < P_MIN) ? P_MIN : m_cur - 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_tick",    32'(o_tick),    32'(m_tick));
            check("model_overrun", 32'(o_overrun), 32'(m_ovr));
            check("model_period",  32'(o_period),  32'(m_cur));
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic vs_edge();
        i_vsync = 1'b1; cyc(1);
        i_vsync = 1'b0; cyc(1);
    endtask

    task automatic vs_edges(input int n);
        repeat (n) vs_edge();
    endtask

    task automatic press_up();
        i_up = 1'b1; cyc(1); i_up = 1'b0; cyc(1);
    endtask

    task automatic press_down();
        i_down = 1'b1; cyc(1); i_down = 1'b0; cyc(1);
    endtask

    task automatic ack();
        i_tick_done = 1'b1; cyc(1); i_tick_done = 1'b0; cyc(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int k, frames, guard, exp_sp;
        cyc(2);
        check("reset_tick",    32'(o_tick),    0);
        check("reset_period",  32'(o_period),  3);
        check("reset_overrun", 32'(o_overrun), 0);
        rst = 1'b0;
        cyc(1);

        // 1: free run, tick after 4th edge, overrun after 8th
        vs_edges(3);
        check("s1_no_tick_3", 32'(o_tick), 0);
        vs_edge();
        check("s1_tick_4", 32'(o_tick), 1);
        vs_edges(3);
        i_vsync = 1'b1; cyc(1);
        check("s1_overrun_8", 32'(o_overrun), 1);
        i_vsync = 1'b0; cyc(1);
        check("s1_overrun_gone", 32'(o_overrun), 0);
        check("s1_tick_held", 32'(o_tick), 1);
        check("s1_period", 32'(o_period), 3);

        // 2: user adjust in restart
        i_restart = 1'b1; cyc(2);
        check("s2_restart_tick", 32'(o_tick), 0);
        i_up = 1'b1; cyc(5); i_up = 1'b0; cyc(1);
        check("s2_hold_single", 32'(o_period), 4);
        press_up(); press_up();
        check("s2_two_more", 32'(o_period), 6);
        repeat (25) press_up();
        check("s2_at_max", 32'(o_period), 31);
        press_up();
        check("s2_sat_max", 32'(o_period), 31);
        repeat (30) press_down();
        check("s2_at_min", 32'(o_period), 1);
        press_down();
        check("s2_sat_min", 32'(o_period), 1);
        i_up = 1'b1; i_down = 1'b1; cyc(1); i_up = 1'b0; i_down = 1'b0; cyc(1);
        check("s2_both", 32'(o_period), 1);
        press_up(); press_up();
        check("s2_back_to_3", 32'(o_period), 3);

        // 3: acceleration, spacing 4 -> 3 -> 2
        i_accel_en = 1'b1; i_restart = 1'b0; cyc(1);
        k = 0; frames = 0; guard = 0;
        while (k < 12 && guard < 200) begin
            vs_edge(); frames++; guard++;
            if (o_tick) begin
                k++;
                exp_sp = (k <= 4) ? 4 : (k <= 8) ? 3 : 2;
                check("s3_spacing", 32'(frames), 32'(exp_sp));
                if (k == 4)  check("s3_period_after4",  32'(o_period), 2);
                if (k == 8)  check("s3_period_after8",  32'(o_period), 1);
                if (k == 12) check("s3_period_after12", 32'(o_period), 1);
                ack(); frames = 0;
            end
        end
        if (k < 12) check("s3_tick_timeout", 32'(k), 12);

        // 4: pause
        i_restart = 1'b1; i_accel_en = 1'b0; cyc(2); i_restart = 1'b0; cyc(1);
        check("s4_period", 32'(o_period), 3);
        vs_edges(4);
        check("s4_first_tick", 32'(o_tick), 1);
        vs_edges(2);
        i_pause = 1'b1; cyc(1);
        vs_edges(10);
        check("s4_paused_held", 32'(o_tick), 1);
        ack();
        check("s4_done_in_pause", 32'(o_tick), 0);
        vs_edges(3);
        check("s4_still_frozen", 32'(o_tick), 0);
        i_pause = 1'b0; cyc(1);
        vs_edge();
        check("s4_resume_1", 32'(o_tick), 0);
        vs_edge();
        check("s4_resume_2", 32'(o_tick), 1);
        ack();

        // 5: due and done together while pending counts as issued
        i_restart = 1'b1; i_accel_en = 1'b1; cyc(2); i_restart = 1'b0; cyc(1);
        vs_edges(4);
        check("s5_tick1", 32'(o_tick), 1);
        repeat (3) begin
            vs_edges(3);
            i_vsync = 1'b1; i_tick_done = 1'b1; cyc(1);
            check("s5_tick_kept", 32'(o_tick), 1);
            check("s5_no_overrun", 32'(o_overrun), 0);
            i_vsync = 1'b0; i_tick_done = 1'b0; cyc(1);
        end
        check("s5_accel_counted", 32'(o_period), 2);

        // 6: restart mid-count, then rst mid-operation
        vs_edge();
        i_restart = 1'b1; cyc(1);
        check("s6_restart_tick", 32'(o_tick), 0);
        check("s6_restart_period", 32'(o_period), 3);
        i_restart = 1'b0; i_accel_en = 1'b0; cyc(1);
        vs_edges(3);
        check("s6_no_tick_3", 32'(o_tick), 0);
        vs_edge();
        check("s6_tick_4", 32'(o_tick), 1);
        ack();
        i_restart = 1'b1; cyc(1); press_up();
        check("s6_base_4", 32'(o_period), 4);
        i_restart = 1'b0; cyc(1);
        vs_edges(2);
        rst = 1'b1; cyc(1);
        check("s6_rst_tick", 32'(o_tick), 0);
        check("s6_rst_period", 32'(o_period), 3);
        check("s6_rst_overrun", 32'(o_overrun), 0);
        rst = 1'b0; cyc(1);
        vs_edges(3);
        check("s6_post_rst_3", 32'(o_tick), 0);
        vs_edge();
        check("s6_post_rst_4", 32'(o_tick), 1);
        i_restart = 1'b1; cyc(2);
        check("s6_base_reset", 32'(o_period), 3);
        i_restart = 1'b0; cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_speed_tickgen
`default_nettype wire

// File: doc/speed_tickgen.md
Name: speed_tickgen

Overview:
Parametrised game-tick generator, successor to the fixed 5-bit tick block. It counts rising edges of vsync and raises a level tick every (period+1) frames; the game core acknowledges each tick with i_tick_done. New over the predecessor:
- saturating (not wrapping) user speed adjustment
- optional automatic acceleration during play
- pause input
- overrun reporting when a tick falls due before the previous one is consumed

Parameters:
CNT_W, 5, width of period and frame counter
DEFAULT_PERIOD, 3, period after reset; frames per tick = period+1
MIN_PERIOD, 1, lower saturation bound (fastest)
MAX_PERIOD, 31, upper saturation bound (slowest); legal when MIN_PERIOD <= DEFAULT_PERIOD <= MAX_PERIOD <= 2^CNT_W-1
ACCEL_EVERY, 4, issued ticks per automatic period decrement; must be >= 1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
i_up  input  1  user up (increase period, slower); sampled only while i_restart=1
i_down  input  1  user down (decrease period, faster); sampled only while i_restart=1
i_restart  input  1  game restart/menu level
i_pause  input  1  freeze frame counting while high
i_accel_en  input  1  enable automatic acceleration
i_vsync  input  1  vsync level from video timing
i_tick_done  input  1  core has consumed the current tick
o_tick  output  1  tick pending (level)
o_period  output  CNT_W  live period in use
o_overrun  output  1  one-cycle pulse: tick due while previous tick still pending

Behaviour:
- All state is updated on posedge clk only. rst has priority over every other input.
- Reset values:
  - base_period = cur_period = DEFAULT_PERIOD
  - counter = 0, accel_cnt = 0
  - o_tick = 0, o_overrun = 0
  - prev_vsync = 0, prev_input = 0
- Frame event: frame = i_vsync & !prev_vsync. prev_vsync is updated every non-reset cycle, including during pause and restart.
- User adjust applies only when i_restart=1 and (i_up|i_down) rises (prev_input = i_up|i_down from the previous cycle):
  - up alone: base_period +1, saturating at MAX_PERIOD
  - down alone: base_period -1, saturating at MIN_PERIOD
  - up and down together: no change
  - A held button gives exactly one step.
- While i_restart=1:
  - counter = 0, o_tick = 0, accel_cnt = 0, o_overrun = 0
  - cur_period <= base_period; this assignment uses the base_period value from before any same-cycle adjust.
  - Net effect: o_period tracks base_period with 1-cycle lag.
- When i_restart=0 and i_pause=1: counter and accel_cnt hold, frames are ignored, and i_tick_done still clears o_tick.
- When i_restart=0, i_pause=0 and frame=1:
  - counter >= cur_period: counter <= 0 and a tick is due. The >= comparison is required because cur_period can drop below counter.
  - otherwise: counter <= counter+1.
- Tick due:
  - o_tick=0, or o_tick=1 with i_tick_done=1 in the same cycle: o_tick <= 1 and the tick counts as issued. Set wins over done.
  - o_tick=1 with i_tick_done=0: o_tick stays 1, o_overrun <= 1 for one cycle, and the tick is not counted as issued.
- With no tick due, i_tick_done=1 clears o_tick the next cycle.
- o_overrun is 0 on every cycle without an overrun event.
- Acceleration (i_accel_en=1, not restart):
  - Each issued tick increments accel_cnt.
  - When accel_cnt would reach ACCEL_EVERY: accel_cnt <= 0 and cur_period <= max(cur_period-1, MIN_PERIOD).
  - With i_accel_en=0, accel_cnt holds and cur_period is unchanged.
- Latency: o_tick rises 1 cycle after the clk edge that samples the vsync rising edge.
- Width rule: all period arithmetic is done in CNT_W+1 bits before the clamp, so no wrap-around is possible.

Decomposition:
- Shared package (common): add typedef for the CNT_W-wide period type and the default constants (DEFAULT_PERIOD, MIN_PERIOD, MAX_PERIOD, ACCEL_EVERY). These replace the single DEFAULT_TICK_COUNTER_MAX.
- One natural sub-module, rise_detect: 1-bit registered rising-edge detector with synchronous active-high reset. Instantiated twice, for vsync and for the up|down input.
- The saturating step is a local function, not a module.

Test Plan:
(defaults CNT_W=5, DEFAULT=3, MIN=1, MAX=31, ACCEL_EVERY=4)
1. Reset; 8 vsync rising edges; no done -> o_tick=1 one cycle after the 4th edge, held; o_overrun single pulse after the 8th edge; o_period=3 throughout.
2. i_restart=1; hold i_up 5 cycles -> o_period 4 (single step); release and press twice more -> 6. From 31, up -> stays 31. From 1, down -> stays 1. up+down together -> unchanged.
3. i_accel_en=1; i_tick_done pulsed after every tick -> o_period goes 3→2 after the 4th tick and 2→1 after the 8th, then stays 1. Tick spacing becomes 4, then 3, then 2 frames.
4. Pause after the 2nd frame of a period; 10 vsync edges -> no tick, counter frozen. Release -> tick after 2 further edges. i_tick_done during pause clears o_tick.
5. Tick due in the same cycle as i_tick_done with o_tick=1 -> o_tick stays 1, no o_overrun, issued-tick count increments.
6. i_restart asserted mid-count with o_tick=1 and cur_period accelerated to 2 -> next cycle o_tick=0, counter=0, o_period=base (3). After release, first tick after 4 edges. rst mid-operation -> all reset values, including base_period=3.
